// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset sequencer: state encoding, domain limits and counter sizing.
package rst_seq_pkg;

  localparam int unsigned MAX_DOMAINS = 8;
  localparam int unsigned IDX_W       = $clog2(MAX_DOMAINS);

  typedef enum logic [2:0] {
    StHold    = 3'd0,
    StStable  = 3'd1,
    StRelease = 3'd2,
    StRun     = 3'd3,
    StDrain   = 3'd4,
    StFault   = 3'd5
  } state_e;

  // The counter is shared between the lock timeout and the stage spacing.
  function automatic int unsigned cnt_width(input int unsigned lock_timeout);
    return $clog2(lock_timeout + 1);
  endfunction

endpackage

// File: rtl/rst_seq_sync2.sv
// Two-flop synchronizer for one asynchronous qualifier; clears to 0 on reset.
module rst_seq_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/rst_seq_ctrl.sv
// Multi-domain reset sequencer: qualifies fabric reset, PLL lock and init, then releases domains
// in ascending order. Define RSTSEQ_ORDERED_ASSERT_EN for descending-order drain on SW request.
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int unsigned NUM_DOMAINS  = 4,
  parameter int unsigned STAGE_DELAY  = 16,
  parameter int unsigned LOCK_TIMEOUT = 1024,
  parameter int unsigned CNT_W        = cnt_width(LOCK_TIMEOUT)
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   FABRIC_RESET_N,
  input  logic                   PLL_LOCK,
  input  logic                   INIT_DONE,
  input  logic                   SW_RST_REQ,
  output logic [NUM_DOMAINS-1:0] DOMAIN_RST_N,
  output logic                   READY,
  output logic                   FAULT,
  output logic [2:0]             STATE
);

  localparam logic [CNT_W-1:0]       STAGE_LAST = CNT_W'(STAGE_DELAY - 1);
  localparam logic [CNT_W-1:0]       TMO_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [IDX_W-1:0]       IDX_LAST   = IDX_W'(NUM_DOMAINS - 1);
  localparam logic [NUM_DOMAINS-1:0] ONE        = NUM_DOMAINS'(1);

  logic fab_s, lock_s, init_s;
  logic ok, tmo_cond, abort;

  state_e                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [IDX_W-1:0]       idx_q;
  logic [NUM_DOMAINS-1:0] dom_q;
  logic                   ready_q;
  logic                   fault_q;
  logic [IDX_W-1:0]       idx_inc;

  rst_seq_sync2 u_sync_fab  (.clk(CLK), .rst(RST), .d(FABRIC_RESET_N), .q(fab_s));
  rst_seq_sync2 u_sync_lock (.clk(CLK), .rst(RST), .d(PLL_LOCK),       .q(lock_s));
  rst_seq_sync2 u_sync_init (.clk(CLK), .rst(RST), .d(INIT_DONE),      .q(init_s));

  assign ok       = fab_s & lock_s & init_s;
  assign tmo_cond = fab_s & init_s & ~lock_s;
  assign idx_inc  = idx_q + IDX_W'(1);

`ifdef RSTSEQ_ORDERED_ASSERT_EN
  logic [IDX_W-1:0] idx_dec;
  assign idx_dec = idx_q - IDX_W'(1);
`endif

  // Qualification loss always wins over any software request on the same edge.
  always_comb begin
    abort = 1'b0;
    case (state_q)
      StStable, StRelease: abort = !ok || SW_RST_REQ;
`ifdef RSTSEQ_ORDERED_ASSERT_EN
      StRun, StDrain:      abort = !ok;
`else
      StRun:               abort = !ok || SW_RST_REQ;
`endif
      default:             abort = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StHold;
      cnt_q   <= '0;
      idx_q   <= '0;
      dom_q   <= '0;
      ready_q <= 1'b0;
      fault_q <= 1'b0;
    end else if (abort) begin
      state_q <= StHold;
      cnt_q   <= '0;
      idx_q   <= '0;
      dom_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        StHold: begin
          dom_q   <= '0;
          ready_q <= 1'b0;
          if (ok) begin
            state_q <= StStable;
            cnt_q   <= '0;
          end else if (tmo_cond) begin
            if (cnt_q == TMO_LAST) begin
              state_q <= StFault;
              fault_q <= 1'b1;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end else begin
            cnt_q <= '0;
          end
        end
        StStable: begin
          if (cnt_q == STAGE_LAST) begin
            state_q <= StRelease;
            cnt_q   <= '0;
            idx_q   <= '0;
            dom_q   <= ONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        StRelease: begin
          if (idx_q == IDX_LAST) begin
            state_q <= StRun;
            ready_q <= 1'b1;
          end else if (cnt_q == STAGE_LAST) begin
            cnt_q <= '0;
            idx_q <= idx_inc;
            dom_q <= dom_q | (ONE << idx_inc);
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        StRun: begin
`ifdef RSTSEQ_ORDERED_ASSERT_EN
          if (SW_RST_REQ) begin
            state_q <= StDrain;
            ready_q <= 1'b0;
            cnt_q   <= '0;
            idx_q   <= IDX_LAST;
            dom_q   <= dom_q & ~(ONE << IDX_LAST);
          end
`endif
        end
`ifdef RSTSEQ_ORDERED_ASSERT_EN
        StDrain: begin
          if (idx_q == '0) begin
            state_q <= StHold;
            cnt_q   <= '0;
          end else if (cnt_q == STAGE_LAST) begin
            cnt_q <= '0;
            idx_q <= idx_dec;
            dom_q <= dom_q & ~(ONE << idx_dec);
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
`endif
        StFault: begin
          if (SW_RST_REQ) begin
            state_q <= StHold;
            fault_q <= 1'b0;
            cnt_q   <= '0;
          end
        end
        default: begin
          state_q <= StHold;
          cnt_q   <= '0;
          idx_q   <= '0;
          dom_q   <= '0;
          ready_q <= 1'b0;
          fault_q <= 1'b0;
        end
      endcase
    end
  end

  assign DOMAIN_RST_N = dom_q;
  assign READY        = ready_q;
  assign FAULT        = fault_q;
  assign STATE        = state_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Scoreboard bench for rst_seq_ctrl: expected output events (edge, value) are queued by the
// stimulus; a negedge monitor pops one whenever the outputs change or an entry falls due.
module tb_rst_seq_ctrl;

  localparam logic [2:0] S_HOLD    = 3'd0;
  localparam logic [2:0] S_STABLE  = 3'd1;
  localparam logic [2:0] S_RELEASE = 3'd2;
  localparam logic [2:0] S_RUN     = 3'd3;
  localparam logic [2:0] S_DRAIN   = 3'd4;
  localparam logic [2:0] S_FAULT   = 3'd5;

  typedef struct {
    int         cyc;
    logic [8:0] tup;
    string      name;
  } exp_t;

  logic       clk, rst, fab, lock, init, sw;
  logic [3:0] dom;
  logic       ready, fault;
  logic [2:0] state;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  logic [8:0] prev = '0;

  rst_seq_ctrl #(
    .NUM_DOMAINS (4),
    .STAGE_DELAY (16),
    .LOCK_TIMEOUT(1024)
  ) dut (
    .CLK           (clk),
    .RST           (rst),
    .FABRIC_RESET_N(fab),
    .PLL_LOCK      (lock),
    .INIT_DONE     (init),
    .SW_RST_REQ    (sw),
    .DOMAIN_RST_N  (dom),
    .READY         (ready),
    .FAULT         (fault),
    .STATE         (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [8:0] tup;
    exp_t       e;
    tup = {state, fault, ready, dom};
    if (q.size() != 0 && (tup !== prev || cyc >= q[0].cyc)) begin
      e = q.pop_front();
      n_cmp++;
      if (tup !== e.tup || cyc != e.cyc) begin
        n_fail++;
        $display("FAIL %s: edge %0d dom=%b ready=%b fault=%b state=%0d, required edge %0d dom=%b ready=%b fault=%b state=%0d",
                 e.name, cyc, tup[3:0], tup[4], tup[5], tup[8:6],
                 e.cyc, e.tup[3:0], e.tup[4], e.tup[5], e.tup[8:6]);
      end
    end else if (q.size() == 0 && tup !== prev) begin
      n_cmp++;
      n_fail++;
      $display("FAIL unexpected_change: edge %0d dom=%b ready=%b fault=%b state=%0d, required no change",
               cyc, tup[3:0], tup[4], tup[5], tup[8:6]);
    end
    prev = tup;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input string name, input int at, input logic [3:0] d, input logic r,
                      input logic f, input logic [2:0] s);
    exp_t e;
    e.cyc  = at;
    e.tup  = {s, f, r, d};
    e.name = name;
    q.push_back(e);
  endtask

  // Full release sequence once HOLD sees ok=1 at edge h.
  task automatic push_reseq(input string name, input int h);
    push({name, "_stable"}, h + 1,  4'b0000, 1'b0, 1'b0, S_STABLE);
    push({name, "_dom0"},   h + 17, 4'b0001, 1'b0, 1'b0, S_RELEASE);
    push({name, "_dom1"},   h + 33, 4'b0011, 1'b0, 1'b0, S_RELEASE);
    push({name, "_dom2"},   h + 49, 4'b0111, 1'b0, 1'b0, S_RELEASE);
    push({name, "_dom3"},   h + 65, 4'b1111, 1'b0, 1'b0, S_RELEASE);
    push({name, "_ready"},  h + 66, 4'b1111, 1'b1, 1'b0, S_RUN);
  endtask

  task automatic wait_drain(input int limit, input string tag);
    for (int i = 0; i < limit && q.size() != 0; i++) step(1);
    if (q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: %0d events pending after %0d cycles, required 0",
               tag, q.size(), limit);
      q.delete();
    end
  endtask

  initial begin
    int c, d;
    rst = 1'b1; fab = 1'b1; lock = 1'b1; init = 1'b1; sw = 1'b0;
    step(3);
    push("reset_vals", cyc, 4'b0000, 1'b0, 1'b0, S_HOLD);
    step(2);

    // Power-up with all qualifiers already high.
    rst = 1'b0;
    c = cyc;
    push_reseq("pwrup", c + 2);
    wait_drain(200, "pwrup");

    // PLL lock loss in RUN, then restore.
    step(1);
    lock = 1'b0;
    c = cyc;
    push("lock_drop", c + 3, 4'b0000, 1'b0, 1'b0, S_HOLD);
    step(10);
    lock = 1'b1;
    d = cyc;
    push_reseq("lock_restore", d + 2);
    wait_drain(200, "lock");

    // Software request in RUN.
    step(1);
    sw = 1'b1;
    c = cyc;
`ifdef RSTSEQ_ORDERED_ASSERT_EN
    push("drain_d3", c + 1,  4'b0111, 1'b0, 1'b0, S_DRAIN);
    push("drain_d2", c + 17, 4'b0011, 1'b0, 1'b0, S_DRAIN);
    push("drain_d1", c + 33, 4'b0001, 1'b0, 1'b0, S_DRAIN);
    push("drain_d0", c + 49, 4'b0000, 1'b0, 1'b0, S_DRAIN);
    push("drain_hold", c + 50, 4'b0000, 1'b0, 1'b0, S_HOLD);
    push_reseq("sw_reseq", c + 50);
`else
    push("sw_run", c + 1, 4'b0000, 1'b0, 1'b0, S_HOLD);
    push_reseq("sw_reseq", c + 1);
`endif
    step(1);
    sw = 1'b0;
    wait_drain(300, "sw_run");

    // INIT loss, restore, then a 5-cycle lock glitch inside the stability window.
    step(1);
    init = 1'b0;
    c = cyc;
    push("init_drop", c + 3, 4'b0000, 1'b0, 1'b0, S_HOLD);
    step(10);
    init = 1'b1;
    d = cyc;
    push("init_stable", d + 3, 4'b0000, 1'b0, 1'b0, S_STABLE);
    step(5);
    lock = 1'b0;
    push("glitch_hold", d + 8, 4'b0000, 1'b0, 1'b0, S_HOLD);
    push("glitch_quiet", d + 10, 4'b0000, 1'b0, 1'b0, S_HOLD);
    step(5);
    lock = 1'b1;
    push_reseq("glitch_reseq", d + 12);
    wait_drain(200, "glitch");

    // SW request coinciding with synchronized INIT loss; then SW in HOLD is ignored.
    step(1);
    init = 1'b0;
    c = cyc;
    step(2);
    sw = 1'b1;
    push("sw_init_hold", c + 3, 4'b0000, 1'b0, 1'b0, S_HOLD);
    step(1);
    sw = 1'b0;
    step(3);
    sw = 1'b1;
    push("sw_in_hold", c + 8, 4'b0000, 1'b0, 1'b0, S_HOLD);
    step(1);
    sw = 1'b0;
    step(3);
    init = 1'b1;
    push_reseq("sw_init_reseq", c + 12);
    wait_drain(200, "sw_init");

    // Async reset in RUN, then lock timeout after release, cleared by SW.
    step(1);
    rst = 1'b1;
    lock = 1'b0;
    c = cyc;
    push("async_rst", c, 4'b0000, 1'b0, 1'b0, S_HOLD);
    step(3);
    rst = 1'b0;
    c = cyc;
    push("lock_timeout", c + 1026, 4'b0000, 1'b0, 1'b1, S_FAULT);
    wait_drain(1200, "timeout");
    step(1);
    sw = 1'b1;
    c = cyc;
    push("fault_clear", c + 1, 4'b0000, 1'b0, 1'b0, S_HOLD);
    step(1);
    sw = 1'b0;
    step(2);
    lock = 1'b1;
    push_reseq("fault_reseq", c + 5);
    wait_drain(200, "fault");

    step(3);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rst_seq_ctrl.md
Name: rst_seq_ctrl

Overview:
- Multi-domain reset sequencer downstream of the PolarFire reset core.
- Qualifies FABRIC_RESET_N, PLL_LOCK and INIT_DONE, then releases NUM_DOMAINS fabric reset domains in ascending order, STAGE_DELAY cycles apart.
- Re-asserts all domain resets on loss of qualification or on a software reset request.
- Reports a sticky FAULT if the PLL never locks.

Parameters:
- NUM_DOMAINS, 4, number of sequenced reset domains (1..8).
- STAGE_DELAY, 16, stability window and inter-domain release spacing in CLK cycles (>=2).
- LOCK_TIMEOUT, 1024, cycles PLL_LOCK may stay low while the other qualifiers are high before FAULT.
- CNT_W, $clog2(LOCK_TIMEOUT+1), counter width (derived; do not override).

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-high reset.
- FABRIC_RESET_N  in  1  reset-core output; async; 1 = fabric out of reset.
- PLL_LOCK  in  1  PLL lock; async.
- INIT_DONE  in  1  device init complete; async.
- SW_RST_REQ  in  1  single-cycle software reset request; synchronous to CLK.
- DOMAIN_RST_N  out  NUM_DOMAINS  per-domain active-low reset; bit 0 released first.
- READY  out  1  all domains released.
- FAULT  out  1  sticky lock-timeout flag.
- STATE  out  3  current FSM state encoding, for debug.

Behaviour:
- Clock and reset: one clock, CLK. RST is asynchronous and active-high. All flops reset asynchronously on RST.
- Reset values: DOMAIN_RST_N=0, READY=0, FAULT=0, STATE=HOLD, counters=0, synchronizer flops=0.
- Synchronization:
  - FABRIC_RESET_N, PLL_LOCK and INIT_DONE each pass through a 2-flop synchronizer; 2-cycle latency.
  - ok = fab_s & lock_s & init_s.
- FSM states (encoding): HOLD=0, STABLE=1, RELEASE=2, RUN=3, DRAIN=4, FAULT=5.
- HOLD:
  - DOMAIN_RST_N all 0.
  - ok=1 -> STABLE, cnt cleared.
  - fab_s & init_s & !lock_s increments the timeout counter. It clears whenever that condition is false.
  - Counter reaching LOCK_TIMEOUT -> FAULT.
- STABLE:
  - cnt increments each cycle while ok=1.
  - ok=0 -> HOLD, cnt cleared.
  - cnt==STAGE_DELAY-1 -> RELEASE with idx=0.
- RELEASE:
  - Entry edge registers DOMAIN_RST_N[idx]=1.
  - Every STAGE_DELAY cycles thereafter idx increments and the next bit is released.
  - After bit NUM_DOMAINS-1 is released, the next edge -> RUN with READY=1.
  - Released bits stay 1.
- RUN: READY=1 and DOMAIN_RST_N all 1.
- Timing with all inputs high from edge 0:
  - DOMAIN_RST_N[0] rises at edge STAGE_DELAY+3.
  - DOMAIN_RST_N[k] rises at edge STAGE_DELAY+3 + k*STAGE_DELAY.
  - READY rises one edge after the last bit.
- Loss of qualification (ok=0 in STABLE/RELEASE/RUN/DRAIN):
  - Next edge forces DOMAIN_RST_N all 0 and READY=0, and enters HOLD.
  - Highest priority.
- SW_RST_REQ:
  - In STABLE/RELEASE/RUN: all domains re-asserted next edge, READY=0, -> HOLD. The sequence then restarts automatically.
  - In HOLD: no effect.
  - In FAULT: clears FAULT and enters HOLD.
- SW_RST_REQ and ok falling on the same edge: the ok-loss path is taken; outcome is identical.
- FAULT:
  - FAULT=1, DOMAIN_RST_N all 0, READY=0.
  - Exits only on RST or SW_RST_REQ.
- RST mid-sequence: immediate asynchronous return to reset values.
- STATE is registered and equals the FSM state register.

Optional Feature:
- Macro: RSTSEQ_ORDERED_ASSERT_EN
- Defined:
  - SW_RST_REQ in RUN enters DRAIN and clears READY next edge.
  - DOMAIN_RST_N[NUM_DOMAINS-1] clears on entry; each lower bit clears STAGE_DELAY cycles later.
  - After bit 0 clears, next edge -> HOLD.
  - ok=0 during DRAIN still clears all bits immediately.
  - SW_RST_REQ in STABLE/RELEASE behaves as when undefined.
- Undefined:
  - DRAIN is unreachable.
  - SW_RST_REQ in RUN asserts all domains at once.

Decomposition:
- Package rst_seq_pkg holds:
  - state encoding constants (3-bit);
  - CNT_W derivation function;
  - MAX_DOMAINS=8.
- Sub-module rst_seq_sync2: 2-flop synchronizer, async active-high clear to 0; instanced once per qualifier.

Test Plan:
- Power-up: RST high 5 cycles, all inputs high, release RST -> DOMAIN_RST_N 0000→0001 at edge 19, 0011 at 35, 0111 at 51, 1111 at 67; READY=1 at edge 68; STATE=3.
- PLL_LOCK pulled low in RUN -> DOMAIN_RST_N=0000 and READY=0 within 3 edges of the drop; PLL_LOCK restored -> full re-sequence, bit 0 released 19 edges after restore.
- Glitch: PLL_LOCK low for 5 cycles during STABLE -> returns to HOLD, no DOMAIN_RST_N bit toggles; stability window restarts from zero.
- Lock timeout: FABRIC_RESET_N=INIT_DONE=1, PLL_LOCK=0 held -> FAULT=1 at edge 2+1024, STATE=5; SW_RST_REQ pulse -> FAULT=0, STATE=0.
- SW_RST_REQ in RUN (macro undefined) -> all bits 0 next edge, re-sequence completes with READY after 66 further edges. With RSTSEQ_ORDERED_ASSERT_EN defined -> bit 3 clears first, bit 0 clears 48 edges later, then HOLD.
- SW_RST_REQ on the same edge as INIT_DONE deassertion (synchronized) -> single entry to HOLD, FAULT stays 0, no spurious READY.
